rv32i_multicycle_ctrl: RTL and testbench
========================================

Name: rv32i_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over a single shared ALU and a single shared memory port.
- Drives imm_src to the immediate sign-extender, plus ALU operand selects, ALU op, register-file and PC/IR write strobes.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal; every other opcode traps.

Parameters:
- OP_LW, 7'b0000011, load opcode
- OP_SW, 7'b0100011, store opcode
- OP_R, 7'b0110011, register ALU opcode
- OP_I, 7'b0010011, immediate ALU opcode
- OP_BEQ, 7'b1100011, branch opcode
- OP_JAL, 7'b1101111, jal opcode

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instr[6:0] from the IR
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write  out  1  load IR and oldPC
- pc_write  out  1  load PC from the result bus
- reg_write  out  1  register-file write enable
- result_src  out  2  result bus select: 00=ALUOut, 01=mem data, 10=ALU result
- alu_src_a  out  2  ALU A select: 00=PC, 01=oldPC, 10=rs1
- alu_src_b  out  2  ALU B select: 00=rs2, 01=imm_ext, 10=const 4
- alu_control  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- imm_src  out  2  extender format: 00=I, 01=S, 10=B, 11=J
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  sticky trap flag

Behaviour:
- State register only; outputs are combinational from state plus op, funct3, funct7b5, zero and mem_ready.
- Any output not listed for a state is 0.
- While rst_n=0: state is FETCH, illegal=0, and all outputs are forced to 0.
- A reset mid-instruction abandons the instruction; no write strobe may be asserted during reset.
- imm_src decodes op in every state:
  - lw and OP_I give 00; sw gives 01; beq gives 10; jal gives 11; any other op gives 00.
- ALU decode, used in EXECUTER and EXECUTEI:
  - funct3 000: add, or sub when op=OP_R and funct7b5=1.
  - funct3 010: slt. 100: xor. 110: or. 111: and.
  - funct3 001, 011 or 101 is illegal.
- States and transitions:
  - FETCH: adr_src=0, mem_read=1, alu_src_a=00, alu_src_b=10, add, result_src=10.
    - ir_write and pc_write equal mem_ready.
    - Stay in FETCH until mem_ready, then go to DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, add; this precomputes the branch/jal target into ALUOut.
    - lw or sw: go to MEMADR. OP_R: EXECUTER. OP_I: EXECUTEI. beq: BEQ. jal: JAL. Anything else: TRAP.
  - MEMADR: alu_src_a=10, alu_src_b=01, add.
    - lw goes to MEMREAD; sw goes to MEMWRITE.
  - MEMREAD: adr_src=1, mem_read=1. Hold until mem_ready, then go to MEMWB.
  - MEMWB: result_src=01, reg_write=1, retire=1. Next state FETCH.
  - MEMWRITE: adr_src=1, mem_write=1. Hold until mem_ready.
    - On mem_ready: retire=1, next state FETCH.
  - EXECUTER: alu_src_a=10, alu_src_b=00, decoded op.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, decoded op.
  - From EXECUTER or EXECUTEI: illegal funct3 goes to TRAP; otherwise go to ALUWB.
  - ALUWB: result_src=00, reg_write=1, retire=1. Next state FETCH.
  - BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00.
    - pc_write=zero, retire=1. Next state FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1. Next state ALUWB (writes rd = oldPC+4).
  - TRAP: illegal=1 sticky. No memory, PC or register writes. Leave only by reset.
- Latency with mem_ready held at 1: lw 5 cycles, sw 4, R/I 4, beq 3, jal 4.
- Every mem_ready wait state extends latency by exactly one cycle.
- mem_read and mem_write are never both 1.
- mem_read/mem_write and adr_src stay stable while waiting for mem_ready.

Test Plan:
- Reset, then release with mem_ready=1 and IR=0x00412083 (lw x1,4(x2)) -> states 0,1,2,3,4.
  - imm_src=00; reg_write=1 and result_src=01 in cycle 5; retire pulse; back to FETCH.
- sw 0x00112223 with mem_ready low for 3 cycles in MEMWRITE -> mem_write=1 and adr_src=1 held for 4 cycles, imm_src=01, retire on the ready cycle, no reg_write.
- R-type sub 0x40208033 -> alu_control=001 in EXECUTER; I-type xori funct3=100 -> alu_control=100 with alu_src_b=01; each reg_write at cycle 4.
- beq 0x00208463 with zero=1 -> pc_write=1 in cycle 3, imm_src=10; repeat with zero=0 -> pc_write=0, retire=1 both times.
- jal 0x008000EF -> JAL asserts pc_write, imm_src=11, alu_src_a=01, alu_src_b=10, then ALUWB reg_write; slli funct3=001 -> TRAP, illegal=1 held, no writes.
- Deassert rst_n while in MEMREAD -> all outputs 0 immediately; after release, FETCH with mem_read=1 and illegal=0.

Source files
------------

// File: rtl/rv32i_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle RV32I main FSM and its datapath.
//   Datapath -> control : op, funct3, funct7b5 (instruction fields from the IR),
//                         zero (ALU flag), mem_ready (memory access completes this cycle).
//   Control -> datapath : memory strobes, IR/PC/register write strobes, mux selects,
//                         ALU op, immediate format, retire pulse and sticky illegal flag.
// master: the controller. slave: the datapath/memory side.
interface rv32i_multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       mem_read;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic       retire;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
        output result_src, alu_src_a, alu_src_b, alu_control, imm_src, retire, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
        input  result_src, alu_src_a, alu_src_b, alu_control, imm_src, retire, illegal
    );
endinterface

// File: rtl/rv32i_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core (lw, sw, R/I ALU, beq, jal).
// Sequences fetch/decode/execute/memory/writeback over one shared ALU and one memory port.
// Ports:
//   clk   - core clock, rising edge
//   rst_n - asynchronous active-low reset; all outputs are forced low while asserted
//   bus   - control bundle (master side), see rv32i_multicycle_ctrl_if
// Only the state is registered; every output is a combinational decode of the state and
// the current instruction fields / zero / mem_ready.
module rv32i_multicycle_ctrl #(
    parameter logic [6:0] OP_LW  = 7'b0000011,
    parameter logic [6:0] OP_SW  = 7'b0100011,
    parameter logic [6:0] OP_R   = 7'b0110011,
    parameter logic [6:0] OP_I   = 7'b0010011,
    parameter logic [6:0] OP_BEQ = 7'b1100011,
    parameter logic [6:0] OP_JAL = 7'b1101111
) (
    input  logic                          clk,
    input  logic                          rst_n,
    rv32i_multicycle_ctrl_if.master       bus
);

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
        StExecR, StExecI, StAluWb, StBeq, StJal, StTrap
    } state_e;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluXor = 3'b100;
    localparam logic [2:0] AluSlt = 3'b101;

    state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // funct3 -> ALU op for EXECUTER/EXECUTEI; funct3 001/011/101 have no support here.
    logic [2:0] alu_dec;
    logic       f3_bad;

    always_comb begin
        alu_dec = AluAdd;
        f3_bad  = 1'b0;
        unique case (bus.funct3)
            3'b000:  alu_dec = (bus.op == OP_R && bus.funct7b5) ? AluSub : AluAdd;
            3'b010:  alu_dec = AluSlt;
            3'b100:  alu_dec = AluXor;
            3'b110:  alu_dec = AluOr;
            3'b111:  alu_dec = AluAnd;
            default: f3_bad  = 1'b1;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.adr_src     = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.result_src  = 2'b00;
        bus.alu_src_a   = 2'b00;
        bus.alu_src_b   = 2'b00;
        bus.alu_control = AluAdd;
        bus.imm_src     = 2'b00;
        bus.retire      = 1'b0;
        bus.illegal     = 1'b0;

        if (bus.op == OP_SW) begin
            bus.imm_src = 2'b01;
        end else if (bus.op == OP_BEQ) begin
            bus.imm_src = 2'b10;
        end else if (bus.op == OP_JAL) begin
            bus.imm_src = 2'b11;
        end

        unique case (state_q)
            StFetch: begin
                bus.mem_read   = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                bus.ir_write   = bus.mem_ready;
                bus.pc_write   = bus.mem_ready;
                if (bus.mem_ready) state_d = StDecode;
            end
            StDecode: begin
                // Branch/jal target (oldPC + imm) is parked in ALUOut here.
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
                if (bus.op == OP_LW || bus.op == OP_SW) state_d = StMemAdr;
                else if (bus.op == OP_R)                state_d = StExecR;
                else if (bus.op == OP_I)                state_d = StExecI;
                else if (bus.op == OP_BEQ)              state_d = StBeq;
                else if (bus.op == OP_JAL)              state_d = StJal;
                else                                    state_d = StTrap;
            end
            StMemAdr: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                state_d = (bus.op == OP_LW) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                bus.adr_src  = 1'b1;
                bus.mem_read = 1'b1;
                if (bus.mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                bus.result_src = 2'b01;
                bus.reg_write  = 1'b1;
                bus.retire     = 1'b1;
                state_d        = StFetch;
            end
            StMemWrite: begin
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
                if (bus.mem_ready) begin
                    bus.retire = 1'b1;
                    state_d    = StFetch;
                end
            end
            StExecR, StExecI: begin
                bus.alu_src_a   = 2'b10;
                bus.alu_src_b   = (state_q == StExecI) ? 2'b01 : 2'b00;
                bus.alu_control = alu_dec;
                state_d         = f3_bad ? StTrap : StAluWb;
            end
            StAluWb: begin
                bus.reg_write = 1'b1;
                bus.retire    = 1'b1;
                state_d       = StFetch;
            end
            StBeq: begin
                bus.alu_src_a   = 2'b10;
                bus.alu_control = AluSub;
                bus.pc_write    = bus.zero;
                bus.retire      = 1'b1;
                state_d         = StFetch;
            end
            StJal: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                bus.pc_write  = 1'b1;
                state_d       = StAluWb;
            end
            StTrap: begin
                // Only reset leaves this state, so the flag is sticky.
                bus.illegal = 1'b1;
            end
            default: state_d = StFetch;
        endcase

        // Reset must not let any strobe through, even before the edge-triggered state
        // register has settled.
        if (!rst_n) begin
            bus.mem_read    = 1'b0;
            bus.mem_write   = 1'b0;
            bus.adr_src     = 1'b0;
            bus.ir_write    = 1'b0;
            bus.pc_write    = 1'b0;
            bus.reg_write   = 1'b0;
            bus.result_src  = 2'b00;
            bus.alu_src_a   = 2'b00;
            bus.alu_src_b   = 2'b00;
            bus.alu_control = AluAdd;
            bus.imm_src     = 2'b00;
            bus.retire      = 1'b0;
            bus.illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
module tb_rv32i_multicycle_ctrl;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv32i_multicycle_ctrl_if bus ();

    rv32i_multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // {mem_read, mem_write, adr_src, ir_write, pc_write, reg_write, result_src,
    //  alu_src_a, alu_src_b, alu_control, imm_src, retire, illegal}
    typedef logic [18:0] outv_t;

    function automatic outv_t mk(logic mr, logic mw, logic as_, logic irw, logic pcw,
                                 logic rw, logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                 logic [2:0] ac, logic [1:0] imm, logic ret, logic ill);
        return {mr, mw, as_, irw, pcw, rw, rs, sa, sb, ac, imm, ret, ill};
    endfunction

    function automatic outv_t actual_out();
        return {bus.mem_read, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.result_src, bus.alu_src_a, bus.alu_src_b,
                bus.alu_control, bus.imm_src, bus.retire, bus.illegal};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic apply(input logic [31:0] instr, input logic z, input logic rdy);
        bus.op        = instr[6:0];
        bus.funct3    = instr[14:12];
        bus.funct7b5  = instr[30];
        bus.zero      = z;
        bus.mem_ready = rdy;
    endtask

    // ---------------- reference model: instruction -> list of phases ----------------
    typedef struct {
        outv_t base;      // outputs while the phase is active
        outv_t done_add;  // extra bits on the cycle a memory wait completes
        bit    waits;     // phase waits for mem_ready
    } step_t;

    step_t plan[$];
    bit    plan_traps;

    function automatic logic [1:0] imm_of(logic [6:0] op);
        if (op == OP_SW)  return 2'b01;
        if (op == OP_BEQ) return 2'b10;
        if (op == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_of(logic [6:0] op, logic [2:0] f3, logic f7);
        case (f3)
            3'd0:    return (op == OP_R && f7) ? 3'd1 : 3'd0;
            3'd2:    return 3'd5;
            3'd4:    return 3'd4;
            3'd6:    return 3'd3;
            3'd7:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic void push(outv_t b, outv_t d, bit w);
        step_t s;
        s.base = b; s.done_add = d; s.waits = w;
        plan.push_back(s);
    endfunction

    function automatic void build(logic [31:0] instr, logic z);
        logic [6:0] op  = instr[6:0];
        logic [2:0] f3  = instr[14:12];
        logic [1:0] imm = imm_of(op);
        outv_t      wb  = mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'd0,imm,1,0);
        bit         bad = (f3 == 3'd1 || f3 == 3'd3 || f3 == 3'd5);
        plan.delete();
        plan_traps = 1'b0;
        push(mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,3'd0,imm,0,0),
             mk(0,0,0,1,1,0,2'b00,2'b00,2'b00,3'd0,2'b00,0,0), 1);
        push(mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,3'd0,imm,0,0), '0, 0);
        if (op == OP_LW || op == OP_SW) begin
            push(mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'd0,imm,0,0), '0, 0);
            if (op == OP_LW) begin
                push(mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,3'd0,imm,0,0), '0, 1);
                push(mk(0,0,0,0,0,1,2'b01,2'b00,2'b00,3'd0,imm,1,0), '0, 0);
            end else begin
                push(mk(0,1,1,0,0,0,2'b00,2'b00,2'b00,3'd0,imm,0,0),
                     mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,2'b00,1,0), 1);
            end
        end else if (op == OP_R || op == OP_I) begin
            push(mk(0,0,0,0,0,0,2'b00,2'b10,(op == OP_I) ? 2'b01 : 2'b00,
                    alu_of(op, f3, instr[30]),imm,0,0), '0, 0);
            if (bad) plan_traps = 1'b1;
            else     push(wb, '0, 0);
        end else if (op == OP_BEQ) begin
            push(mk(0,0,0,0,z,0,2'b00,2'b10,2'b00,3'd1,imm,1,0), '0, 0);
        end else if (op == OP_JAL) begin
            push(mk(0,0,0,0,1,0,2'b00,2'b01,2'b10,3'd0,imm,0,0), '0, 0);
            push(wb, '0, 0);
        end else begin
            plan_traps = 1'b1;
        end
    endfunction

    // Walk the model's phases cycle by cycle; rnd randomises mem_ready (bounded waits).
    task automatic run_plan(input string name, input logic [31:0] instr, input logic z,
                            input bit rnd);
        outv_t exp;
        logic  rdy;
        int    waits;
        build(instr, z);
        for (int i = 0; i < plan.size(); i++) begin
            waits = 0;
            forever begin
                @(negedge clk);
                rdy = rnd ? (($urandom_range(0, 2) != 0) || waits >= 5) : 1'b1;
                apply(instr, z, rdy);
                #1;
                exp = plan[i].base | ((plan[i].waits && rdy) ? plan[i].done_add : '0);
                check(name, 32'(actual_out()), 32'(exp));
                if (!plan[i].waits || rdy) break;
                waits++;
            end
        end
        if (plan_traps) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                apply(instr, z, 1'($urandom_range(0, 1)));
                #1;
                check({name, "_trap"}, 32'(actual_out()),
                      32'(mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,imm_of(instr[6:0]),0,1)));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.op = OP_SW;  // a non-zero imm_src would show if outputs leaked through reset
        bus.mem_ready = 1'b1;
        #1;
        check("reset_outputs_zero", 32'(actual_out()), 32'd0);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed table, mem_ready held high ----------------
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        z;
        int          lat;
        logic [1:0]  imm;
        int          pcw_cnt;
        int          rw_cnt;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v);
        int cyc = 0, pcw = 0, rw = 0, both = 0;
        logic [1:0] imm0 = 2'b00;
        bit done = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            apply(v.instr, v.z, 1'b1);
            #1;
            cyc++;
            if (cyc == 1) imm0 = bus.imm_src;
            pcw += int'(bus.pc_write);
            rw  += int'(bus.reg_write);
            both += int'(bus.mem_read & bus.mem_write);
            done = bus.retire;
        end
        check({v.name, "_latency"}, 32'(cyc), 32'(v.lat));
        check({v.name, "_imm_src"}, 32'(imm0), 32'(v.imm));
        check({v.name, "_pc_writes"}, 32'(pcw), 32'(v.pcw_cnt));
        check({v.name, "_reg_writes"}, 32'(rw), 32'(v.rw_cnt));
        check({v.name, "_rd_wr_excl"}, 32'(both), 32'd0);
    endtask

    initial begin
        logic [6:0]  pool [8];
        logic [31:0] instr;

        vecs[0] = '{"lw",    32'h00412083, 1'b0, 5, 2'b00, 1, 1};
        vecs[1] = '{"sw",    32'h00112223, 1'b0, 4, 2'b01, 1, 0};
        vecs[2] = '{"sub",   32'h40208033, 1'b0, 4, 2'b00, 1, 1};
        vecs[3] = '{"xori",  32'h0050C093, 1'b0, 4, 2'b00, 1, 1};
        vecs[4] = '{"beq_t", 32'h00208463, 1'b1, 3, 2'b10, 2, 0};
        vecs[5] = '{"beq_n", 32'h00208463, 1'b0, 3, 2'b10, 1, 0};
        vecs[6] = '{"jal",   32'h008000EF, 1'b0, 4, 2'b11, 2, 1};
        vecs[7] = '{"add",   32'h002081B3, 1'b0, 4, 2'b00, 1, 1};

        apply(32'h0, 1'b0, 1'b0);
        do_reset();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Per-cycle model comparison of the Test Plan instructions.
        run_plan("lw_trace",   32'h00412083, 1'b0, 0);
        run_plan("sub_trace",  32'h40208033, 1'b0, 0);
        run_plan("xori_trace", 32'h0050C093, 1'b0, 0);
        run_plan("beq_trace",  32'h00208463, 1'b1, 0);
        run_plan("jal_trace",  32'h008000EF, 1'b0, 0);

        // sw with three wait cycles in MEMWRITE.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            apply(32'h00112223, 1'b0, 1'b1);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            apply(32'h00112223, 1'b0, 1'b0);
            #1;
            check("sw_wait", 32'(actual_out()),
                  32'(mk(0,1,1,0,0,0,2'b00,2'b00,2'b00,3'd0,2'b01,0,0)));
        end
        @(negedge clk);
        apply(32'h00112223, 1'b0, 1'b1);
        #1;
        check("sw_ready", 32'(actual_out()),
              32'(mk(0,1,1,0,0,0,2'b00,2'b00,2'b00,3'd0,2'b01,1,0)));

        // slli (funct3 001) traps; illegal sticks with no writes until reset.
        run_plan("slli_trap", 32'h00109093, 1'b0, 0);
        do_reset();
        @(negedge clk);
        apply(32'h00412083, 1'b0, 1'b0);
        #1;
        check("post_trap_fetch", 32'(actual_out()),
              32'(mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,3'd0,2'b00,0,0)));

        // Reset while waiting in MEMREAD.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            apply(32'h00412083, 1'b0, 1'b1);
        end
        @(negedge clk);
        apply(32'h00412083, 1'b0, 1'b0);
        #1;
        check("memread_wait", 32'(actual_out()),
              32'(mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,3'd0,2'b00,0,0)));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_in_memread", 32'(actual_out()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("fetch_after_reset", 32'(actual_out()),
              32'(mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,3'd0,2'b00,0,0)));

        // Randomised instructions and memory latency against the phase model.
        pool = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, 7'b0110111, 7'b0000000};
        for (int n = 0; n < 60; n++) begin
            instr = $urandom;
            instr[6:0] = pool[$urandom_range(0, 7)];
            run_plan("random", instr, 1'($urandom_range(0, 1)), 1);
            if (plan_traps) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
